sdram_port_arbiter: RTL and testbench



---
 rtl/sdram_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Two-master front end for the single SDRAM controller. Master 0 is the CPU
//   memory path and master 1 is the DMA/blitter engine. When both request at
//   once, the tie goes round-robin. The winning request is latched and driven
//   to the controller. The command acknowledge, read-ready and read data are
//   routed back to the master that was granted. A read-completion timeout
//   makes sure a missing s_ready cannot hang the arbiter.
//
// Ports
//   clk, rst           system clock; synchronous active-high reset
//   mX_addr/wdata      master X address and write data
//   mX_read/write      master X request levels, held until mX_cack
//   mX_cack            one-cycle pulse: command accepted by the controller
//   mX_ready           one-cycle pulse: mX_rdata valid
//   mX_busy            arbiter occupied
//   mX_rdata           last read data returned to master X
//   s_*                handshake to/from the SDRAM controller
//   timeout_err        sticky flag, set when a read timed out
//
// state   | meaning
// IDLE    | sample requests, arbitrate and grant when s_busy is low
// ISSUE   | command driven to the controller, waiting for s_cack
// WAIT_RD | read accepted, waiting for s_ready or the timeout
module sdram_port_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [15:0]       m0_wdata,
  input  logic              m0_read,
  input  logic              m0_write,
  output logic              m0_cack,
  output logic              m0_ready,
  output logic              m0_busy,
  output logic [31:0]       m0_rdata,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [15:0]       m1_wdata,
  input  logic              m1_read,
  input  logic              m1_write,
  output logic              m1_cack,
  output logic              m1_ready,
  output logic              m1_busy,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [15:0]       s_wdata,
  output logic              s_read,
  output logic              s_write,
  input  logic              s_busy,
  input  logic              s_ready,
  input  logic              s_cack,
  input  logic [31:0]       s_rdata,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic              grant, grant_n;          // 0 = m0, 1 = m1
  logic              op_wr, op_wr_n;
  logic              last_grant, last_grant_n;
  logic [TO_W-1:0]   cnt, cnt_n;

  logic [ADDR_W-1:0] s_addr_n;
  logic [15:0]       s_wdata_n;
  logic              s_read_n, s_write_n;
  logic              m0_cack_n, m1_cack_n, m0_ready_n, m1_ready_n, busy_n;
  logic [31:0]       m0_rdata_n, m1_rdata_n;
  logic              timeout_err_n;

  logic              req0, req1, pick;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // Tie goes to the master that did not win last time.
  assign pick = (req0 && req1) ? ~last_grant : req1;

  always_comb begin
    state_n       = state;
    grant_n       = grant;
    op_wr_n       = op_wr;
    last_grant_n  = last_grant;
    cnt_n         = cnt;
    s_addr_n      = s_addr;
    s_wdata_n     = s_wdata;
    s_read_n      = s_read;
    s_write_n     = s_write;
    m0_cack_n     = 1'b0;
    m1_cack_n     = 1'b0;
    m0_ready_n    = 1'b0;
    m1_ready_n    = 1'b0;
    m0_rdata_n    = m0_rdata;
    m1_rdata_n    = m1_rdata;
    timeout_err_n = timeout_err;

    case (state)
      IDLE: begin
        if (!s_busy && (req0 || req1)) begin
          grant_n      = pick;
          last_grant_n = pick;
          // A read and a write raised together are treated as a write.
          op_wr_n      = pick ? m1_write : m0_write;
          s_addr_n     = pick ? m1_addr  : m0_addr;
          s_wdata_n    = pick ? m1_wdata : m0_wdata;
          s_write_n    = op_wr_n;
          s_read_n     = ~op_wr_n;
          state_n      = ISSUE;
        end
      end
      ISSUE: begin
        if (s_cack) begin
          s_read_n  = 1'b0;
          s_write_n = 1'b0;
          m0_cack_n = ~grant;
          m1_cack_n = grant;
          if (op_wr) begin
            state_n = IDLE;
          end else begin
            cnt_n   = '0;
            state_n = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (s_ready) begin
          if (grant) m1_rdata_n = s_rdata;
          else       m0_rdata_n = s_rdata;
          m0_ready_n = ~grant;
          m1_ready_n = grant;
          state_n    = IDLE;
        end else if (cnt == TO_LAST) begin
          if (grant) m1_rdata_n = '0;
          else       m0_rdata_n = '0;
          m0_ready_n    = ~grant;
          m1_ready_n    = grant;
          timeout_err_n = 1'b1;
          state_n       = IDLE;
        end else begin
          cnt_n = cnt + TO_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      op_wr       <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_read      <= 1'b0;
      s_write     <= 1'b0;
      m0_cack     <= 1'b0;
      m1_cack     <= 1'b0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_busy     <= 1'b0;
      m1_busy     <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      op_wr       <= op_wr_n;
      last_grant  <= last_grant_n;
      cnt         <= cnt_n;
      s_addr      <= s_addr_n;
      s_wdata     <= s_wdata_n;
      s_read      <= s_read_n;
      s_write     <= s_write_n;
      m0_cack     <= m0_cack_n;
      m1_cack     <= m1_cack_n;
      m0_ready    <= m0_ready_n;
      m1_ready    <= m1_ready_n;
      m0_busy     <= busy_n;
      m1_busy     <= busy_n;
      m0_rdata    <= m0_rdata_n;
      m1_rdata    <= m1_rdata_n;
      timeout_err <= timeout_err_n;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: write, read, round-robin, read
// timeout, reset during a read, combined read+write request and s_busy hold.
module tb_sdram_port_arbiter;
  localparam int ADDR_W  = 23;
  localparam int TIMEOUT = 64;
  localparam int TO_W    = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [15:0]       m0_wdata, m1_wdata;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic              m0_cack, m0_ready, m0_busy, m1_cack, m1_ready, m1_busy;
  logic [31:0]       m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] s_addr;
  logic [15:0]       s_wdata;
  logic              s_read, s_write, s_busy, s_ready, s_cack;
  logic [31:0]       s_rdata;
  logic              timeout_err;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
    .m0_cack(m0_cack), .m0_ready(m0_ready), .m0_busy(m0_busy), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
    .m1_cack(m1_cack), .m1_ready(m1_ready), .m1_busy(m1_busy), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_read(s_read), .s_write(s_write),
    .s_busy(s_busy), .s_ready(s_ready), .s_cack(s_cack), .s_rdata(s_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Pulse / level counters, sampled mid-cycle.
  int c_m0_cack = 0, c_m1_cack = 0, c_m0_ready = 0, c_m1_ready = 0;
  int c_s_read = 0, c_s_write = 0;
  always @(negedge clk) begin
    if (m0_cack)  c_m0_cack++;
    if (m1_cack)  c_m1_cack++;
    if (m0_ready) c_m0_ready++;
    if (m1_ready) c_m1_ready++;
    if (s_read)   c_s_read++;
    if (s_write)  c_s_write++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int s_w0, s_r0, a0, a1, b0, b1, n;

  initial begin
    rst = 1'b1;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    s_busy = 0; s_ready = 0; s_cack = 0; s_rdata = '0;
    step(); step();
    rst = 1'b0;
    check_val("rst_s_write", s_write, 0);
    check_val("rst_s_read", s_read, 0);
    check_val("rst_s_addr", s_addr, 0);
    check_val("rst_busy", {m0_busy, m1_busy}, 0);
    check_val("rst_terr", timeout_err, 0);

    // 1: m0 write, s_cack in the third issue cycle
    s_w0 = c_s_write; a1 = c_m1_cack; b1 = c_m1_ready;
    m0_addr = 23'h000123; m0_wdata = 16'hBEEF; m0_write = 1;
    step();
    check_val("t1_s_write", s_write, 1);
    check_val("t1_s_addr", s_addr, 32'h000123);
    check_val("t1_s_wdata", s_wdata, 32'hBEEF);
    check_val("t1_busy", m0_busy, 1);
    step(); step();
    s_cack = 1;
    step();
    s_cack = 0; m0_write = 0;
    check_val("t1_m0_cack", m0_cack, 1);
    check_val("t1_s_write_clr", s_write, 0);
    check_val("t1_idle_busy", m0_busy, 0);
    step();
    check_val("t1_cack_1cyc", m0_cack, 0);
    check_val("t1_write_cycles", c_s_write - s_w0, 3);
    check_val("t1_m1_quiet", (c_m1_cack - a1) + (c_m1_ready - b1), 0);

    // 2: m1 read, s_ready four cycles after cack
    m1_addr = 23'h7FFFFF; m1_read = 1;
    step();
    check_val("t2_s_read", s_read, 1);
    check_val("t2_s_addr", s_addr, 32'h7FFFFF);
    s_cack = 1;
    step();
    s_cack = 0; m1_read = 0;
    check_val("t2_m1_cack", m1_cack, 1);
    check_val("t2_busy_wait", m1_busy, 1);
    step(); step(); step(); step();
    s_ready = 1; s_rdata = 32'hCAFEF00D;
    step();
    s_ready = 0;
    check_val("t2_m1_ready", m1_ready, 1);
    check_val("t2_m1_rdata", m1_rdata, 32'hCAFEF00D);
    check_val("t2_m0_rdata", m0_rdata, 0);
    step();
    check_val("t2_ready_1cyc", m1_ready, 0);
    check_val("t2_rdata_hold", m1_rdata, 32'hCAFEF00D);

    // 3: continuous tie of writes from reset
    rst = 1;
    step();
    rst = 0;
    m0_addr = 23'h000AAA; m1_addr = 23'h000555;
    m0_write = 1; m1_write = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val($sformatf("t3_addr%0d", i), s_addr, (i % 2 == 0) ? 32'h000AAA : 32'h000555);
      s_cack = 1;
      step();
      s_cack = 0;
      check_val($sformatf("t3_cack%0d", i), {m1_cack, m0_cack}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 3) begin
        m0_write = 0; m1_write = 0;
      end
    end
    step();
    check_val("t3_idle", {s_write, m0_busy}, 0);

    // 4: good m0 read, then an m0 read whose s_ready never comes
    m0_read = 1;
    step();
    s_cack = 1;
    step();
    s_cack = 0; m0_read = 0;
    s_ready = 1; s_rdata = 32'h12345678;
    step();
    s_ready = 0;
    check_val("t4_rdata", m0_rdata, 32'h12345678);
    m0_read = 1;
    step();
    s_cack = 1;
    step();
    s_cack = 0; m0_read = 0;
    check_val("t4_m0_cack", m0_cack, 1);
    n = 0;
    do begin
      step();
      n++;
      if (n < TIMEOUT && timeout_err) begin
        check_val("t4_terr_early", timeout_err, 0);
      end
    end while (!m0_ready && n < 200);
    check_val("t4_to_cycles", n, TIMEOUT);
    check_val("t4_to_rdata", m0_rdata, 0);
    check_val("t4_terr", timeout_err, 1);
    step();
    check_val("t4_ready_1cyc", m0_ready, 0);
    m1_addr = 23'h000042; m1_write = 1;
    step();
    check_val("t4_m1_s_addr", s_addr, 32'h000042);
    s_cack = 1;
    step();
    s_cack = 0; m1_write = 0;
    check_val("t4_m1_cack", m1_cack, 1);
    check_val("t4_terr_sticky", timeout_err, 1);
    step();

    // 5: reset while waiting for read data
    m1_read = 1;
    step();
    s_cack = 1;
    step();
    s_cack = 0; m1_read = 0;
    step(); step();
    rst = 1;
    step();
    check_val("t5_rst_sread", {s_read, s_write}, 0);
    check_val("t5_rst_busy", {m0_busy, m1_busy}, 0);
    check_val("t5_rst_rdata", m1_rdata, 0);
    check_val("t5_rst_terr", timeout_err, 0);
    a0 = c_m0_ready; b0 = c_m1_ready;
    rst = 0; s_ready = 1; s_rdata = 32'hDEADBEEF;
    step();
    s_ready = 0;
    step();
    check_val("t5_no_ready", (c_m0_ready - a0) + (c_m1_ready - b0), 0);
    check_val("t5_rdata_zero", m1_rdata, 0);
    m0_addr = 23'h000111; m1_addr = 23'h000222;
    m0_write = 1; m1_write = 1;
    step();
    check_val("t5_tie_addr", s_addr, 32'h000111);
    s_cack = 1;
    m0_write = 0; m1_write = 0;
    step();
    s_cack = 0;
    check_val("t5_tie_cack", {m1_cack, m0_cack}, 2'b01);
    step();

    // 6: s_busy holds arbitration; read+write together issues a write
    s_r0 = c_s_read;
    s_busy = 1; m0_read = 1; m0_write = 1; m0_addr = 23'h000333;
    step(); step();
    check_val("t6_hold", {s_read, s_write, m0_busy}, 0);
    s_busy = 0;
    step();
    check_val("t6_s_write", s_write, 1);
    check_val("t6_s_read", s_read, 0);
    s_cack = 1;
    step();
    s_cack = 0; m0_read = 0; m0_write = 0;
    check_val("t6_cack", m0_cack, 1);
    step();
    check_val("t6_read_never", c_s_read - s_r0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
